piso_shift_tx: RTL

- Parallel-in, serial-out shift transmitter with a valid/ready load handshake.
- Accepts a WIDTH-bit word and drives it out one bit per enabled clock, with a frame-start marker and a last-bit marker.
- It is the transmit end of the team's serial register link. It feeds a serial-in, parallel-out capture register on the far side.
- Built from the same register primitive style as the team's D flip-flops: an async active-low reset plus a synchronous active-low clear.

---
 rtl/piso_shift_tx_if.sv | 25 ++
 rtl/piso_shift_tx.sv | 110 +++++++++++
 2 files changed

// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial output bundle for the PISO transmitter.
// The master drives words and the bit-rate enable; the slave is the transmitter.
interface piso_shift_tx_if #(
   parameter int unsigned WIDTH = 8
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             shift_en;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_first;
   logic             ser_last;
   logic             busy;

   modport master (
      output load_valid, load_data, shift_en,
      input  load_ready, ser_out, ser_valid, ser_first, ser_last, busy
   );

   modport slave (
      input  load_valid, load_data, shift_en,
      output load_ready, ser_out, ser_valid, ser_first, ser_last, busy
   );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: loads a word on valid/ready and shifts it
// out one bit per shift_en edge, flagging the first and last bit of each frame.
module piso_shift_tx #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic            clk,
   input logic            reset_n,
   input logic            clear_b,
   piso_shift_tx_if.slave bus
);
   localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned   HEAD = MSB_FIRST ? (WIDTH - 1) : 0;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             first_q, first_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] shifted_c;
   logic             load_ready_c;

   // Move the word one place toward the head, zero-filling the tail.
   always_comb begin
      if (MSB_FIRST) shifted_c = {sreg_q[WIDTH-2:0], 1'b0};
      else           shifted_c = {1'b0, sreg_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d      = state_q;
      sreg_d       = sreg_q;
      cnt_d        = cnt_q;
      load_ready_c = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            load_ready_c = 1'b1;
            if (bus.load_valid) begin
               sreg_d  = bus.load_data;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bus.shift_en) begin
               if (cnt_q == LAST) begin
                  // Last-bit edge doubles as the back-to-back load slot.
                  load_ready_c = 1'b1;
                  cnt_d        = '0;
                  if (bus.load_valid) begin
                     sreg_d = bus.load_data;
                  end else begin
                     sreg_d  = '0;
                     state_d = S_IDLE;
                  end
               end else begin
                  sreg_d = shifted_c;
                  cnt_d  = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (!clear_b) begin
         state_d = S_IDLE;
         sreg_d  = '0;
         cnt_d   = '0;
      end
   end

   // Frame flags are registered from the next-state view so they track the shift register.
   always_comb begin
      valid_d = (state_d == S_SHIFT);
      first_d = valid_d && (cnt_d == '0);
      last_d  = valid_d && (cnt_d == LAST);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         first_q <= first_d;
         last_q  <= last_d;
      end
   end

   assign bus.load_ready = load_ready_c;
   assign bus.ser_out    = sreg_q[HEAD];
   assign bus.ser_valid  = valid_q;
   assign bus.ser_first  = first_q;
   assign bus.ser_last   = last_q;
   assign bus.busy       = valid_q;
endmodule
